// File: rtl/picoblaze_io_hub_if.sv
// PicoBlaze (kcpsm3) I/O bus bundle: port address, strobes, data in both directions and
// the interrupt/acknowledge pair. The core drives through master, the hub answers on slave.
interface picoblaze_io_hub_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic [7:0] out_port;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, out_port, read_strobe, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, write_strobe, out_port, read_strobe, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/picoblaze_io_hub.sv
// I/O and interrupt hub for a PicoBlaze core: output/input port decode, registered read mux,
// and a maskable rising-edge interrupt controller with an interrupt/interrupt_ack handshake.
module picoblaze_io_hub #(
    parameter int         N_OUT    = 4,
    parameter int         N_IN     = 4,
    parameter int         N_IRQ    = 4,
    parameter logic [7:0] BASE_OUT = 8'h00,
    parameter logic [7:0] BASE_IN  = 8'h00,
    parameter logic [7:0] IRQ_BASE = 8'hF0
) (
    input  logic                 clk,
    input  logic                 reset,
    picoblaze_io_hub_if.slave    bus,
    output logic [8*N_OUT-1:0]   out_data,
    output logic [N_OUT-1:0]     out_wr,
    input  logic [8*N_IN-1:0]    in_data,
    output logic [N_IN-1:0]      in_rd,
    input  logic [N_IRQ-1:0]     irq_src
);

    localparam logic [7:0] STAT_ADDR = IRQ_BASE;
    localparam logic [7:0] MASK_ADDR = IRQ_BASE + 8'd1;
    localparam logic [7:0] CLR_ADDR  = IRQ_BASE + 8'd2;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [N_IRQ-1:0]   mask;
    logic [N_IRQ-1:0]   pending, pending_nxt;
    logic [N_IRQ-1:0]   active;
    logic [N_IRQ-1:0]   clr_bits;
    logic [N_IRQ-1:0]   irq_edge;
    logic [N_IRQ-1:0]   irq_meta_p0, irq_sync_p1, irq_dly_p2;
    logic [7:0]         out_off, in_off;
    logic               stat_hit, mask_hit, clr_hit, irq_hit;
    logic [N_OUT-1:0]   out_sel;
    logic [N_IN-1:0]    in_sel;
    logic [7:0]         rd_data;

    // Address decode; the interrupt register window shadows any overlapping data port
    always_comb begin
        out_off  = bus.port_id - BASE_OUT;
        in_off   = bus.port_id - BASE_IN;
        stat_hit = (bus.port_id == STAT_ADDR);
        mask_hit = (bus.port_id == MASK_ADDR);
        clr_hit  = (bus.port_id == CLR_ADDR);
        irq_hit  = stat_hit | mask_hit | clr_hit;
        out_sel  = '0;
        in_sel   = '0;
        for (int k = 0; k < N_OUT; k++)
            out_sel[k] = !irq_hit && (out_off == 8'(k));
        for (int k = 0; k < N_IN; k++)
            in_sel[k] = !irq_hit && (in_off == 8'(k));
    end

    always_comb begin
        rd_data = '0;
        if (stat_hit) begin
            rd_data[N_IRQ-1:0] = active;
        end else if (mask_hit) begin
            rd_data[N_IRQ-1:0] = mask;
        end else begin
            for (int k = 0; k < N_IN; k++)
                if (in_sel[k]) rd_data = in_data[8*k +: 8];
        end
    end

    // A fresh edge beats a same-cycle clear so no request is ever dropped
    always_comb begin
        clr_bits    = (bus.write_strobe && clr_hit) ? bus.out_port[N_IRQ-1:0] : '0;
        irq_edge    = irq_sync_p1 & ~irq_dly_p2;
        pending_nxt = (pending & ~clr_bits) | irq_edge;
        active      = pending & mask;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|active) state_nxt = REQ;
            REQ: begin
                if (!(|active))             state_nxt = IDLE;
                else if (bus.interrupt_ack) state_nxt = SERVICE;
            end
            SERVICE: if (!(|active)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data      <= '0;
            out_wr        <= '0;
            in_rd         <= '0;
            bus.in_port   <= '0;
            bus.interrupt <= 1'b0;
            mask          <= '0;
            pending       <= '0;
            irq_meta_p0   <= '0;
            irq_sync_p1   <= '0;
            irq_dly_p2    <= '0;
            state         <= IDLE;
        end else begin
            for (int k = 0; k < N_OUT; k++)
                if (bus.write_strobe && out_sel[k]) out_data[8*k +: 8] <= bus.out_port;
            out_wr        <= bus.write_strobe ? out_sel : '0;
            in_rd         <= bus.read_strobe ? in_sel : '0;
            bus.in_port   <= rd_data;
            if (bus.write_strobe && mask_hit) mask <= bus.out_port[N_IRQ-1:0];
            pending       <= pending_nxt;
            // Two-flop synchroniser, then a delayed copy for edge detection
            irq_meta_p0   <= irq_src;
            irq_sync_p1   <= irq_meta_p0;
            irq_dly_p2    <= irq_sync_p1;
            state         <= state_nxt;
            bus.interrupt <= (state_nxt == REQ);
        end
    end

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Scenario-driven bench for picoblaze_io_hub with randomized port traffic and irq patterns
// checked against a spec-level model of port contents, mask and pending bits.
module tb_picoblaze_io_hub;
    localparam int         N_OUT    = 4;
    localparam int         N_IN     = 4;
    localparam int         N_IRQ    = 4;
    localparam logic [7:0] BASE_OUT = 8'h00;
    localparam logic [7:0] BASE_IN  = 8'h00;
    localparam logic [7:0] IRQ_BASE = 8'hF0;
    localparam logic [7:0] STAT_A   = IRQ_BASE;
    localparam logic [7:0] MASK_A   = IRQ_BASE + 8'd1;
    localparam logic [7:0] CLR_A    = IRQ_BASE + 8'd2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    picoblaze_io_hub_if bus();
    logic [8*N_OUT-1:0] out_data;
    logic [N_OUT-1:0]   out_wr;
    logic [8*N_IN-1:0]  in_data;
    logic [N_IN-1:0]    in_rd;
    logic [N_IRQ-1:0]   irq_src;

    picoblaze_io_hub #(
        .N_OUT(N_OUT), .N_IN(N_IN), .N_IRQ(N_IRQ),
        .BASE_OUT(BASE_OUT), .BASE_IN(BASE_IN), .IRQ_BASE(IRQ_BASE)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .out_data(out_data), .out_wr(out_wr), .in_data(in_data),
        .in_rd(in_rd), .irq_src(irq_src)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]       exp_out [N_OUT];
    logic [N_IRQ-1:0] exp_mask;
    logic [N_IRQ-1:0] exp_pending;

    function automatic logic [8*N_OUT-1:0] exp_out_vec();
        logic [8*N_OUT-1:0] v;
        for (int k = 0; k < N_OUT; k++) v[8*k +: 8] = exp_out[k];
        return v;
    endfunction

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.port_id = addr;
        bus.out_port = data;
        bus.write_strobe = 1'b1;
        @(posedge clk); #1;
        bus.write_strobe = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] addr, output logic [7:0] data, output logic [N_IN-1:0] rd);
        @(negedge clk);
        bus.port_id = addr;
        bus.read_strobe = 1'b0;
        @(posedge clk); #1;
        bus.read_strobe = 1'b1;
        @(posedge clk); #1;
        data = bus.in_port;
        rd = in_rd;
        bus.read_strobe = 1'b0;
    endtask

    task automatic wait_int(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (bus.interrupt) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.interrupt_ack = 1'b1;
        @(posedge clk); #1;
        bus.interrupt_ack = 1'b0;
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL ack_drop: interrupt=%b required 0", bus.interrupt);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_data !== '0 || out_wr !== '0 || in_rd !== '0 || bus.in_port !== 8'h00 || bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_data=%h out_wr=%b in_rd=%b in_port=%h int=%b required all 0",
                     out_data, out_wr, in_rd, bus.in_port, bus.interrupt);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < N_OUT; k++) exp_out[k] = 8'h00;
        exp_mask = '0;
        exp_pending = '0;
    endtask

    task automatic test_out_write();
        logic [N_OUT-1:0] exp_wr;
        int off;
        logic [7:0] d;
        cpu_write(BASE_OUT + 8'd2, 8'hA5);
        exp_out[2] = 8'hA5;
        checks++;
        if (out_data[23:16] !== 8'hA5 || out_wr !== 4'b0100) begin
            errors++;
            $display("FAIL write_port2: data=%h wr=%b required A5 0100", out_data[23:16], out_wr);
        end
        @(posedge clk); #1;
        checks++;
        if (out_wr !== '0) begin
            errors++;
            $display("FAIL write_pulse_width: wr=%b required 0", out_wr);
        end
        for (int i = 0; i < 30; i++) begin
            off = $urandom_range(0, 15);
            d = 8'($urandom);
            cpu_write(BASE_OUT + 8'(off), d);
            exp_wr = '0;
            if (off < N_OUT) begin
                exp_out[off] = d;
                exp_wr[off] = 1'b1;
            end
            checks++;
            if (out_data !== exp_out_vec() || out_wr !== exp_wr) begin
                errors++;
                $display("FAIL write_rand port=%0d: data=%h wr=%b required %h %b",
                         off, out_data, out_wr, exp_out_vec(), exp_wr);
            end
        end
    endtask

    task automatic test_in_read();
        logic [7:0] d;
        logic [N_IN-1:0] rd;
        logic [N_IN-1:0] exp_rd;
        logic [7:0] exp_d;
        int off;
        in_data = {8'h3C, 24'($urandom)};
        cpu_read(BASE_IN + 8'd3, d, rd);
        checks++;
        if (d !== 8'h3C || rd !== 4'b1000) begin
            errors++;
            $display("FAIL read_port3: in_port=%h in_rd=%b required 3C 1000", d, rd);
        end
        @(posedge clk); #1;
        checks++;
        if (in_rd !== '0) begin
            errors++;
            $display("FAIL read_pulse_width: in_rd=%b required 0", in_rd);
        end
        cpu_read(8'h80, d, rd);
        checks++;
        if (d !== 8'h00 || rd !== '0) begin
            errors++;
            $display("FAIL read_unmapped: in_port=%h in_rd=%b required 00 0", d, rd);
        end
        for (int i = 0; i < 20; i++) begin
            in_data = 32'($urandom);
            off = $urandom_range(0, 9);
            cpu_read(BASE_IN + 8'(off), d, rd);
            exp_rd = '0;
            exp_d = 8'h00;
            if (off < N_IN) begin
                exp_rd[off] = 1'b1;
                exp_d = in_data[8*off +: 8];
            end
            checks++;
            if (d !== exp_d || rd !== exp_rd) begin
                errors++;
                $display("FAIL read_rand port=%0d: in_port=%h in_rd=%b required %h %b", off, d, rd, exp_d, exp_rd);
            end
        end
    endtask

    task automatic test_irq_basic();
        bit seen;
        logic [7:0] d;
        logic [N_IN-1:0] rd;
        cpu_write(MASK_A, 8'h01);
        exp_mask = 4'h1;
        @(negedge clk);
        irq_src[0] = 1'b1;
        exp_pending[0] = 1'b1;
        wait_int(4, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL irq_basic_assert: interrupt=0 required 1 within 4 cycles");
        end
        do_ack();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL irq_service_hold: interrupt=%b required 0", bus.interrupt);
        end
        cpu_write(CLR_A, 8'h01);
        exp_pending[0] = 1'b0;
        irq_src[0] = 1'b0;
        cpu_read(STAT_A, d, rd);
        checks++;
        if (d !== {4'h0, exp_pending & exp_mask} || bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL irq_basic_clear: status=%h int=%b required %h 0", d, bus.interrupt, exp_pending & exp_mask);
        end
    endtask

    task automatic test_irq_masked();
        bit seen;
        logic [7:0] d;
        logic [N_IN-1:0] rd;
        cpu_write(MASK_A, 8'h00);
        exp_mask = '0;
        @(negedge clk);
        irq_src[1] = 1'b1;
        exp_pending[1] = 1'b1;
        wait_int(6, seen);
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL irq_masked_quiet: interrupt=1 required 0");
        end
        cpu_read(STAT_A, d, rd);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL irq_masked_status: status=%h required 00", d);
        end
        cpu_write(MASK_A, 8'h02);
        exp_mask = 4'h2;
        wait_int(4, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL irq_unmask_assert: interrupt=0 required 1");
        end
        cpu_read(STAT_A, d, rd);
        checks++;
        if (d !== {4'h0, exp_pending & exp_mask}) begin
            errors++;
            $display("FAIL irq_retained_status: status=%h required %h", d, exp_pending & exp_mask);
        end
        do_ack();
        cpu_write(CLR_A, 8'h02);
        exp_pending[1] = 1'b0;
        irq_src[1] = 1'b0;
    endtask

    task automatic test_irq_set_wins();
        bit seen;
        logic [7:0] d;
        logic [N_IN-1:0] rd;
        cpu_write(MASK_A, 8'h01);
        exp_mask = 4'h1;
        @(negedge clk);
        irq_src[0] = 1'b1;
        exp_pending[0] = 1'b1;
        wait_int(4, seen);
        do_ack();
        @(negedge clk);
        irq_src[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        irq_src[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.port_id = CLR_A;
        bus.out_port = 8'h01;
        bus.write_strobe = 1'b1;
        @(posedge clk); #1;
        bus.write_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_no_rereq: interrupt=%b required 0 while serviced", bus.interrupt);
        end
        cpu_read(STAT_A, d, rd);
        checks++;
        if (d !== {4'h0, exp_pending & exp_mask}) begin
            errors++;
            $display("FAIL set_wins_status: status=%h required %h", d, exp_pending & exp_mask);
        end
        cpu_write(MASK_A, 8'h00);
        cpu_write(MASK_A, 8'h01);
        wait_int(4, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL set_wins_rereq: interrupt=0 required 1 after service ended");
        end
        do_ack();
        cpu_write(CLR_A, 8'h01);
        exp_pending[0] = 1'b0;
        irq_src[0] = 1'b0;
    endtask

    task automatic test_irq_random();
        logic [N_IRQ-1:0] nsrc;
        logic [N_IRQ-1:0] clr;
        logic [7:0] d;
        logic [N_IN-1:0] rd;
        for (int i = 0; i < 10; i++) begin
            nsrc = N_IRQ'($urandom);
            @(negedge clk);
            exp_pending = exp_pending | (nsrc & ~irq_src);
            irq_src = nsrc;
            repeat (4) @(posedge clk);
            if ($urandom_range(0, 1) == 1) begin
                clr = N_IRQ'($urandom);
                cpu_write(CLR_A, {4'h0, clr});
                exp_pending = exp_pending & ~clr;
            end
            exp_mask = N_IRQ'($urandom);
            cpu_write(MASK_A, {4'h0, exp_mask});
            cpu_read(STAT_A, d, rd);
            checks++;
            if (d !== {4'h0, exp_pending & exp_mask}) begin
                errors++;
                $display("FAIL irq_rand_status iter=%0d: status=%h required %h", i, d, exp_pending & exp_mask);
            end
            cpu_read(MASK_A, d, rd);
            checks++;
            if (d !== {4'h0, exp_mask}) begin
                errors++;
                $display("FAIL irq_rand_mask iter=%0d: mask=%h required %h", i, d, exp_mask);
            end
        end
        cpu_write(MASK_A, 8'h00);
        exp_mask = '0;
        irq_src = '0;
        repeat (4) @(posedge clk);
        cpu_write(CLR_A, 8'hFF);
        exp_pending = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [7:0] d;
        logic [N_IN-1:0] rd;
        cpu_write(BASE_OUT + 8'd1, 8'h5A);
        exp_out[1] = 8'h5A;
        cpu_write(MASK_A, 8'h01);
        exp_mask = 4'h1;
        @(negedge clk);
        irq_src[0] = 1'b1;
        wait_int(4, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_setup: interrupt=0 required 1");
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < N_OUT; k++) exp_out[k] = 8'h00;
        exp_mask = '0;
        exp_pending = '0;
        checks++;
        if (bus.interrupt !== 1'b0 || out_data !== exp_out_vec()) begin
            errors++;
            $display("FAIL reset_mid_async: int=%b out_data=%h required 0 %h", bus.interrupt, out_data, exp_out_vec());
        end
        irq_src[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cpu_read(MASK_A, d, rd);
        checks++;
        if (d !== {4'h0, exp_mask}) begin
            errors++;
            $display("FAIL reset_mid_mask: mask=%h required %h", d, exp_mask);
        end
        cpu_write(MASK_A, 8'h01);
        exp_mask = 4'h1;
        wait_int(6, seen);
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_lost_edge: interrupt=1 required 0");
        end
        cpu_read(STAT_A, d, rd);
        checks++;
        if (d !== {4'h0, exp_pending & exp_mask}) begin
            errors++;
            $display("FAIL reset_mid_status: status=%h required %h", d, exp_pending & exp_mask);
        end
    endtask

    initial begin
        bus.port_id = 8'h00;
        bus.write_strobe = 1'b0;
        bus.out_port = 8'h00;
        bus.read_strobe = 1'b0;
        bus.interrupt_ack = 1'b0;
        in_data = '0;
        irq_src = '0;
        test_reset();
        test_out_write();
        test_in_read();
        test_irq_basic();
        test_irq_masked();
        test_irq_set_wins();
        test_irq_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
